sram_port_master: RTL and testbench

SRAM_PORT_MASTER -- requirements
Module: sram_port_master

---
 rtl/sram_port_master.sv | 106 ++++++++++
 tb/tb_sram_port_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_master.sv
// Single-port SRAM master: accepts word requests, drives the SRAM, returns in-order responses.
// Optional macro SRAM_PORT_MASTER_ERR_EN: zero-byte-enable writes are not issued and return rsp_err=1.
module sram_port_master #(
  parameter int RSP_DEPTH = 2,
  parameter int AW        = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [3:0]    req_be,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_di,
  output logic [AW-1:0] mem_a,
  input  logic [31:0]   mem_do
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0] occ;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          infl_valid, infl_we;
  logic [CW:0]   used;
  logic          accept, issue, be_err, push, pop;
  logic [31:0]   buf_rdata [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check counts the inflight slot so the buffer can never overflow.
  always_comb begin
    used      = {1'b0, occ} + {{CW{1'b0}}, infl_valid};
    req_ready = !RST && (used < (CW+1)'(RSP_DEPTH));
    accept    = req_valid && req_ready;
  end

`ifdef SRAM_PORT_MASTER_ERR_EN
  assign be_err = req_we && (req_be == 4'b0000);
`else
  assign be_err = 1'b0;
`endif

  always_comb begin
    issue  = accept && !be_err;
    mem_en = issue;
    mem_we = (issue && req_we) ? req_be : 4'b0000;
    mem_a  = req_addr;
    mem_di = req_wdata;
  end

  assign push      = infl_valid;
  assign rsp_valid = !RST && (occ != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? buf_rdata[rd_ptr] : 32'h0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      infl_valid <= 1'b0;
      infl_we    <= 1'b0;
    end else begin
      infl_valid <= accept;
      infl_we    <= req_we;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
    end
  end

  // Write responses (including rejected ones) carry zero data.
  always_ff @(posedge CLK) begin
    if (!RST && push) buf_rdata[wr_ptr] <= infl_we ? 32'h0 : mem_do;
  end

`ifdef SRAM_PORT_MASTER_ERR_EN
  logic infl_err;
  logic buf_err [RSP_DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) infl_err <= 1'b0;
    else     infl_err <= be_err;
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) buf_err[wr_ptr] <= infl_err;
  end

  assign rsp_err = rsp_valid && buf_err[rd_ptr];
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_master.sv
// Directed bench for sram_port_master: depth-2 instance for function/backpressure/reset,
// depth-3 instance for full-rate streaming; each has a behavioural SRAM.
module tb_sram_port_master;

`ifdef SRAM_PORT_MASTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_mem_en;
  logic [3:0]  a_req_be, a_mem_we;
  logic [11:0] a_req_addr, a_mem_a;
  logic [31:0] a_req_wdata, a_rsp_rdata, a_mem_di, a_mem_do;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_mem_en;
  logic [3:0]  b_req_be, b_mem_we;
  logic [11:0] b_req_addr, b_mem_a;
  logic [31:0] b_req_wdata, b_rsp_rdata, b_mem_di, b_mem_do;

  sram_port_master #(.RSP_DEPTH(2), .AW(12)) u_d2 (
    .CLK(CLK), .RST(RST),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we), .req_be(a_req_be),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_di(a_mem_di), .mem_a(a_mem_a), .mem_do(a_mem_do)
  );

  sram_port_master #(.RSP_DEPTH(3), .AW(12)) u_d3 (
    .CLK(CLK), .RST(RST),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_be(b_req_be),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_di(b_mem_di), .mem_a(b_mem_a), .mem_do(b_mem_do)
  );

  // Unwritten words read back as C0FFEE followed by the low address byte.
  logic [31:0] sram_a [256];
  logic [31:0] sram_b [256];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram_a[i] <= {24'hC0FFEE, 8'(i)};
    end else if (a_mem_en) begin
      a_mem_do <= sram_a[a_mem_a[7:0]];
      for (int n = 0; n < 4; n++)
        if (a_mem_we[n]) sram_a[a_mem_a[7:0]][8*n +: 8] <= a_mem_di[8*n +: 8];
    end
  end

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram_b[i] <= {24'hC0FFEE, 8'(i)};
    end else if (b_mem_en) begin
      b_mem_do <= sram_b[b_mem_a[7:0]];
      for (int n = 0; n < 4; n++)
        if (b_mem_we[n]) sram_b[b_mem_a[7:0]][8*n +: 8] <= b_mem_di[8*n +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic we, input logic [3:0] be, input logic [11:0] addr, input logic [31:0] wd);
    bit got = 0;
    a_req_valid = 1'b1; a_req_we = we; a_req_be = be; a_req_addr = addr; a_req_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (a_req_ready) begin got = 1; break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $error("FAIL send_timeout: observed no req_ready expected req_ready within 20 cycles");
    end
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (a_rsp_valid) begin got = 1; break; end
      @(posedge CLK); #1;
    end
    if (got) begin
      chk({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
      chk({tag, "_err"}, 32'(a_rsp_err), 32'(exp_err));
    end else begin
      checks++; errors++;
      $error("FAIL %s_timeout: observed no rsp_valid expected rsp_valid within 20 cycles", tag);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; mem_init = 1'b1;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'hF; a_req_addr = 12'h010; a_req_wdata = 32'hBAD0BAD0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = 4'h0; b_req_addr = 12'h000; b_req_wdata = 32'h0;
    @(posedge CLK); #1;
    mem_init = 1'b0;

    // Reset: a request offered during reset must not reach the SRAM
    @(negedge CLK);
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; a_req_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("post_rst_b_req_ready", 32'(b_req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge CLK); #1;

    // Full write then read-back, 2-cycle latency
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'hF; a_req_addr = 12'h010; a_req_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    chk("wr_ready", 32'(a_req_ready), 32'd1);
    chk("wr_mem_en", 32'(a_mem_en), 32'd1);
    chk("wr_mem_we", 32'(a_mem_we), 32'hF);
    chk("wr_mem_a", 32'(a_mem_a), 32'h010);
    chk("wr_mem_di", a_mem_di, 32'hDEADBEEF);
    @(posedge CLK); #1;
    a_req_we = 1'b0; a_req_be = 4'h0; a_req_wdata = 32'h0;
    @(negedge CLK);
    chk("rd_ready", 32'(a_req_ready), 32'd1);
    chk("rd_mem_en", 32'(a_mem_en), 32'd1);
    chk("rd_mem_we", 32'(a_mem_we), 32'd0);
    chk("rd_rsp_valid_early", 32'(a_rsp_valid), 32'd0);
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    @(negedge CLK);
    chk("idle_mem_en", 32'(a_mem_en), 32'd0);
    chk("wr_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("wr_rsp_rdata", a_rsp_rdata, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rd_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", 32'(a_rsp_err), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("drained_rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge CLK); #1;

    // Partial byte-enable merge
    send(1'b1, 4'hF, 12'h020, 32'hAABBCCDD);
    get_rsp("w_full", 32'h0, 1'b0);
    send(1'b1, 4'b0101, 12'h020, 32'h11223344);
    get_rsp("w_part", 32'h0, 1'b0);
    send(1'b0, 4'h0, 12'h020, 32'h0);
    get_rsp("rmw", 32'hAA22CC44, 1'b0);

    // Backpressure on depth 2: two accepted, then stall with a stable head
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_be = 4'h0; a_req_addr = 12'h010;
    @(negedge CLK);
    chk("bp_acc0", 32'(a_req_ready), 32'd1);
    @(posedge CLK); #1;
    a_req_addr = 12'h020;
    @(negedge CLK);
    chk("bp_acc1", 32'(a_req_ready), 32'd1);
    @(posedge CLK); #1;
    a_req_addr = 12'h030;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_stall_ready", 32'(a_req_ready), 32'd0);
      chk("bp_stall_mem_en", 32'(a_mem_en), 32'd0);
      chk("bp_head_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_head_rdata", a_rsp_rdata, 32'hDEADBEEF);
      @(posedge CLK); #1;
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_out0_valid", 32'(a_rsp_valid), 32'd1);
    chk("bp_out0_rdata", a_rsp_rdata, 32'hDEADBEEF);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_out1_valid", 32'(a_rsp_valid), 32'd1);
    chk("bp_out1_rdata", a_rsp_rdata, 32'hAA22CC44);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_empty", 32'(a_rsp_valid), 32'd0);
    @(posedge CLK); #1;

    // Write with no byte enables
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'h0; a_req_addr = 12'h010; a_req_wdata = 32'h12345678;
    @(negedge CLK);
    chk("be0_ready", 32'(a_req_ready), 32'd1);
    chk("be0_mem_en", 32'(a_mem_en), ERR_EN ? 32'd0 : 32'd1);
    chk("be0_mem_we", 32'(a_mem_we), 32'd0);
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    get_rsp("be0_rsp", 32'h0, ERR_EN);
    send(1'b0, 4'h0, 12'h010, 32'h0);
    get_rsp("be0_after", 32'hDEADBEEF, 1'b0);

    // Reset with two responses buffered
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 12'h010;
    @(posedge CLK); #1;
    a_req_addr = 12'h020;
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre_rst_valid", 32'(a_rsp_valid), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; a_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("no_stale_valid", 32'(a_rsp_valid), 32'd0);
      chk("no_stale_rdata", a_rsp_rdata, 32'd0);
      @(posedge CLK); #1;
    end
    send(1'b0, 4'h0, 12'h020, 32'h0);
    get_rsp("post_rst_rd", 32'hAA22CC44, 1'b0);
    @(negedge CLK);
    chk("post_rst_empty", 32'(a_rsp_valid), 32'd0);
    @(posedge CLK); #1;

    // Depth 3 streaming: one accept and one response per cycle, pointers wrap
    for (int k = 0; k < 11; k++) begin
      logic [7:0] lo;
      lo = 8'(64 + k - 2);
      if (k < 8) begin
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_be = 4'h0; b_req_addr = 12'(64 + k);
      end else begin
        b_req_valid = 1'b0;
      end
      @(negedge CLK);
      if (k < 8) begin
        chk("s_ready", 32'(b_req_ready), 32'd1);
        chk("s_mem_en", 32'(b_mem_en), 32'd1);
        chk("s_mem_a", 32'(b_mem_a), 32'(64 + k));
      end
      if (k >= 2 && k < 10) begin
        chk("s_rsp_valid", 32'(b_rsp_valid), 32'd1);
        chk("s_rsp_rdata", b_rsp_rdata, {24'hC0FFEE, lo});
        chk("s_rsp_err", 32'(b_rsp_err), 32'd0);
      end else begin
        chk("s_rsp_idle", 32'(b_rsp_valid), 32'd0);
      end
      @(posedge CLK); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
